// File: rtl/nr_div_iter_pkg.sv
// Shared types, widths and the seed reciprocal table for the iterative
// Newton-Raphson significand divider.
package nr_div_iter_pkg;

  localparam int W   = 58;   // 1.57 operand / approximation width
  localparam int PW  = 116;  // full 58x58 product width, format 2.114
  localparam int EBW = 115;  // back-multiplied product width, format 2.113

  localparam logic [1:0] ITER_DB = 2'd3;
  localparam logic [1:0] ITER_SP = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MULA,
    ST_MULB,
    ST_QUOT,
    ST_BACK,
    ST_DONE
  } state_t;

  // Seed x0 = 1 / (1 + (idx + 0.5)/256) in 1.57, i.e. the reciprocal of the
  // midpoint of the divisor interval selected by the top 8 fraction bits.
  function automatic logic [W-1:0] recip_entry(input logic [7:0] idx);
    logic [66:0] num;
    logic [66:0] den;
    num = 67'd1 << 66;
    den = {57'd0, 1'b1, idx, 1'b1};
    return W'(num / den);
  endfunction

endpackage

// File: rtl/mul58.sv
// Purely combinational 58x58 -> 116 unsigned multiplier shared by every
// arithmetic state of the divider.
module mul58
  import nr_div_iter_pkg::*;
(
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] p
);

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/nr_div_iter.sv
// Newton-Raphson quotient approximation engine: seeds 1/Db from a table,
// refines it, then forms E = Da*x and the back-product Eb = E*Db.
module nr_div_iter
  import nr_div_iter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [52:0]    fa,
  input  logic [52:0]    fb,
  input  logic           db_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   Da,
  output logic [W-1:0]   Db,
  output logic [W-1:0]   E,
  output logic [EBW-1:0] Eb,
  output logic           db
);

  state_t         state;
  logic [1:0]     cnt;
  logic [W-1:0]   x;
  logic [W-1:0]   a_r;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [PW-1:0]  prod;
  logic [W-1:0]   prod_t;
  logic           unused_lsb;
  logic [W-1:0]   recip_rom [256];

  // NOTE: entries are elaboration-time constants, so the divide in
  // recip_entry folds away and only a ROM reaches hardware.
  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign recip_rom[g] = recip_entry(8'(g));
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      ST_MULA: begin op_a = Db; op_b = x;    end
      ST_MULB: begin op_a = x;  op_b = ~a_r; end
      ST_QUOT: begin op_a = Da; op_b = x;    end
      ST_BACK: begin op_a = E;  op_b = Db;   end
      default: ;
    endcase
  end

  mul58 u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // All 1.57 results sit in product bits [114:57]; the back-product keeps
  // both integer bits and drops only the last fraction bit.
  assign prod_t     = prod[114:57];
  assign unused_lsb = prod[0];

  // NOTE: reset is tested inside the clocked block because it is synchronous;
  // non-blocking assignments keep every register update edge-aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Da        <= '0;
      Db        <= '0;
      E         <= '0;
      Eb        <= '0;
      db        <= 1'b0;
      cnt       <= '0;
      x         <= '0;
      a_r       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            Da       <= {fa, 5'b0};
            Db       <= {fb, 5'b0};
            db       <= db_in;
            in_ready <= 1'b0;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          x     <= recip_rom[Db[56:49]];
          cnt   <= db ? ITER_DB : ITER_SP;
          state <= ST_MULA;
        end
        ST_MULA: begin
          a_r   <= prod_t;
          state <= ST_MULB;
        end
        ST_MULB: begin
          x     <= prod_t;
          cnt   <= cnt - 2'd1;
          state <= (cnt == 2'd1) ? ST_QUOT : ST_MULA;
        end
        ST_QUOT: begin
          E     <= prod_t;
          state <= ST_BACK;
        end
        ST_BACK: begin
          Eb        <= prod[PW-1:1];
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_div_iter.sv
// Directed and randomized checks of nr_div_iter against an exact-arithmetic
// quotient model with error bounds.
module tb_nr_div_iter;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [52:0]    fa;
  logic [52:0]    fb;
  logic           db_in;
  logic           out_valid;
  logic           out_ready;
  logic [57:0]    Da;
  logic [57:0]    Db;
  logic [57:0]    E;
  logic [114:0]   Eb;
  logic           db;

  int checks = 0;
  int errors = 0;

  localparam logic [52:0] ONE     = 53'h10_0000_0000_0000;
  localparam logic [52:0] ONE_P5  = 53'h18_0000_0000_0000;
  localparam logic [52:0] ALL_ONE = 53'h1F_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  nr_div_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fa        (fa),
    .fb        (fb),
    .db_in     (db_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Da        (Da),
    .Db        (Db),
    .E         (E),
    .Eb        (Eb),
    .db        (db)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [127:0] obs,
                             input logic [127:0] lo, input logic [127:0] hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h..%0h", tag, obs, lo, hi);
    end
  endtask

  // Exact floor(a/b * 2^57): the ideal 1.57 quotient of two 1.52 significands.
  function automatic logic [127:0] ref_q(input logic [52:0] a, input logic [52:0] b);
    logic [127:0] num;
    num = {18'd0, a, 57'd0};
    return num / {75'd0, b};
  endfunction

  function automatic logic [52:0] rand_sig(input logic d);
    logic [63:0] r;
    logic [52:0] s;
    r = {$urandom, $urandom};
    s = {1'b1, r[51:0]};
    if (!d) s[28:0] = '0;
    return s;
  endfunction

  task automatic launch(input logic [52:0] a, input logic [52:0] b, input logic d);
    int n;
    n = 0;
    fa = a; fb = b; db_in = d; in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("accept ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lat, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 40);
    check({tag, " latency"}, 128'(n), 128'(lat));
  endtask

  // The estimate converges from below, so E never exceeds the exact quotient.
  task automatic check_result(input logic [52:0] a, input logic [52:0] b,
                              input logic d, input string tag);
    logic [127:0] q;
    logic [127:0] lo;
    logic [115:0] p;
    q  = ref_q(a, b);
    lo = d ? q - 128'd16 : q - (128'd1 << 29);
    check({tag, " Da"}, 128'(Da), 128'({a, 5'b0}));
    check({tag, " Db"}, 128'(Db), 128'({b, 5'b0}));
    check({tag, " db"}, 128'(db), 128'(d));
    check_range({tag, " E"}, 128'(E), lo, q);
    p = 116'(E) * 116'({b, 5'b0});
    check({tag, " Eb"}, 128'(Eb), 128'(p[115:1]));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " drained valid"}, 128'(out_valid), 128'(0));
    check({tag, " drained ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [52:0]  a1, b1, a2, b2;
    logic [57:0]  e_hold;
    logic [114:0] eb_hold;
    logic         d;
    int           pulses;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fa = '0; fb = '0; db_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  128'(in_ready),  128'(1));
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset Da",        128'(Da),        128'(0));
    check("reset Db",        128'(Db),        128'(0));
    check("reset E",         128'(E),         128'(0));
    check("reset Eb",        128'(Eb),        128'(0));
    check("reset db",        128'(db),        128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0 / 1.0 in double: just under one.
    launch(ONE, ONE, 1'b1);
    wait_valid(9, "one_one");
    check_result(ONE, ONE, 1'b1, "one_one");
    check_range("one_one E near 1", 128'(E), (128'd1 << 57) - 128'd2, 128'd1 << 57);
    drain("one_one");

    // 1.5 / 1.0 in single.
    launch(ONE_P5, ONE, 1'b0);
    wait_valid(7, "one_p5");
    check_result(ONE_P5, ONE, 1'b0, "one_p5");
    drain("one_p5");

    // Largest divisor: last table entry, result near 0.5 + 2^-54.
    launch(ONE, ALL_ONE, 1'b1);
    wait_valid(9, "max_div");
    check_result(ONE, ALL_ONE, 1'b1, "max_div");
    check_range("max_div E", 128'(E), (128'd1 << 56) + 128'd4, (128'd1 << 56) + 128'd12);
    drain("max_div");

    // Consumer stall with stray in_valid pulses.
    a1 = rand_sig(1'b1); b1 = rand_sig(1'b1);
    launch(a1, b1, 1'b1);
    wait_valid(9, "stall");
    check_result(a1, b1, 1'b1, "stall");
    e_hold = E; eb_hold = Eb;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      fa = rand_sig(1'b1); fb = rand_sig(1'b1); db_in = 1'b0;
      @(posedge clk); #1;
      check("stall out_valid", 128'(out_valid), 128'(1));
      check("stall in_ready",  128'(in_ready),  128'(0));
      check("stall Da",        128'(Da),        128'({a1, 5'b0}));
      check("stall E",         128'(E),         128'(e_hold));
      check("stall Eb",        128'(Eb),        128'(eb_hold));
      check("stall db",        128'(db),        128'(1));
    end
    in_valid = 1'b0;
    drain("stall");

    // Reset in the middle of a double operation.
    launch(rand_sig(1'b1), rand_sig(1'b1), 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst Da",  128'(Da),  128'(0));
    check("midrst Db",  128'(Db),  128'(0));
    check("midrst E",   128'(E),   128'(0));
    check("midrst Eb",  128'(Eb),  128'(0));
    check("midrst db",  128'(db),  128'(0));
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("midrst no out_valid", 128'(pulses), 128'(0));
    check("midrst in_ready",     128'(in_ready), 128'(1));

    // Back-to-back with in_valid held high across the first operation.
    a1 = rand_sig(1'b1); b1 = rand_sig(1'b1);
    a2 = rand_sig(1'b0); b2 = rand_sig(1'b0);
    fa = a1; fb = b1; db_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    fa = a2; fb = b2; db_in = 1'b0;
    wait_valid(9, "b2b first");
    check_result(a1, b1, 1'b1, "b2b first");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b idle in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b second accepted", 128'(in_ready), 128'(0));
    wait_valid(7, "b2b second");
    check_result(a2, b2, 1'b0, "b2b second");
    drain("b2b");

    // Random operands, random precision, random consumer delay.
    for (int i = 0; i < 12; i++) begin
      d  = 1'($urandom_range(0, 1));
      a1 = rand_sig(d);
      b1 = rand_sig(d);
      launch(a1, b1, d);
      wait_valid(d ? 9 : 7, "rand");
      check_result(a1, b1, d, "rand");
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      check("rand held valid", 128'(out_valid), 128'(1));
      drain("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
